pc_fetch_unit: RTL



---
 rtl/pc_fetch_unit_pkg.sv | 20 ++
 rtl/pc_fetch_unit_return_stack.sv | 68 ++++++
 rtl/pc_fetch_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_pkg
// Constants and types shared by the fetch unit and its return stack.
//   PC_WIDTH_C      program counter width (8K-word program space)
//   STACK_DEPTH_C   hardware return-stack entries (power of two)
//   RESET_VECTOR_C  PC value after reset
//   NOP_WORD_C      word placed in the instruction register on reset/flush
// ---------------------------------------------------------------------------
package pc_fetch_unit_pkg;

  localparam int              PC_WIDTH_C     = 13;
  localparam int              INSTR_WIDTH_C  = 14;
  localparam int              STACK_DEPTH_C  = 8;
  localparam logic [12:0]     RESET_VECTOR_C = 13'h0000;
  localparam logic [13:0]     NOP_WORD_C     = 14'h0000;

  typedef logic [PC_WIDTH_C-1:0]    pc_t;
  typedef logic [INSTR_WIDTH_C-1:0] instr_t;

endpackage

// File: rtl/pc_fetch_unit_return_stack.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_return_stack
// Circular hardware return stack with sticky overflow/underflow flags.
//   clk, rst        clock, synchronous active-high reset
//   push, pop       push din / pop; pop wins when both are asserted
//   din             return address to store on push
//   top             entry at sp-1 (the pop target), valid combinationally
//   depth           number of live entries, saturating at STACK_DEPTH
//   overflow        sticky: push seen while full (oldest entry overwritten)
//   underflow       sticky: pop seen while empty (stale entry returned)
// ---------------------------------------------------------------------------
module pc_fetch_unit_return_stack
  import pc_fetch_unit_pkg::*;
#(
  parameter int STACK_DEPTH = STACK_DEPTH_C,
  parameter int WIDTH       = PC_WIDTH_C,
  localparam int SP_W       = $clog2(STACK_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [SP_W:0]    depth,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [SP_W-1:0] SP_ONE     = SP_W'(1);
  localparam logic [SP_W:0]   DEPTH_ONE  = (SP_W+1)'(1);
  localparam logic [SP_W:0]   DEPTH_FULL = (SP_W+1)'(STACK_DEPTH);

  logic [WIDTH-1:0] entries [STACK_DEPTH];
  logic [SP_W-1:0]  sp;
  logic [SP_W-1:0]  sp_prev;
  logic             push_eff;

  // A simultaneous pop cancels the push entirely.
  assign push_eff = push && !pop;
  // sp is exactly SP_W bits wide, so the subtraction wraps modulo the depth.
  assign sp_prev  = sp - SP_ONE;
  assign top      = entries[sp_prev];

  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= '0;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (pop) begin
      sp <= sp_prev;
      if (depth == '0) underflow <= 1'b1;
      else             depth     <= depth - DEPTH_ONE;
    end else if (push_eff) begin
      sp <= sp + SP_ONE;
      if (depth == DEPTH_FULL) overflow <= 1'b1;
      else                     depth    <= depth + DEPTH_ONE;
    end
  end

  // NOTE: the entry array is deliberately left out of reset; its contents are
  // don't-care until written, and a reset-free array maps onto plain storage.
  always_ff @(posedge clk) begin
    if (!rst && push_eff) entries[sp] <= din;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Owns the program counter, the return stack and the instruction register.
// Presents pc to program memory (asynchronous ROM) and applies the PC
// redirections requested by the decoder.
//   clk, rst              clock, synchronous active-high reset
//   incr_pc_en            pc <= pc + 1 (wraps)
//   load_pc_en            pc <= {pclath[4:3], load_pc_addr}   (goto/call)
//   load_pc_addr[10:0]    literal k from goto/call
//   pcl_wr_en             pc <= {pclath, pcl_wr_data}         (computed goto)
//   pcl_wr_data[7:0]      new PCL value
//   pclath[4:0]           PCLATH register contents
//   push_en / pop_en      return-stack push (call) / pop (return family)
//   instr_rd_en           capture pmem_rd_data into instr_current
//   instr_flush           replace instr_current with NOP_WORD (beats rd_en)
//   pmem_addr[12:0]       program-memory address (= pc)
//   pmem_rd_data[13:0]    program-memory word at pmem_addr
//   instr_current[13:0]   instruction register, feeds the decoder
//   pc[12:0], pcl[7:0]    current PC and its low byte
//   stack_overflow/underflow  sticky return-stack error flags
// ---------------------------------------------------------------------------
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int          PC_WIDTH     = PC_WIDTH_C,
  parameter int          STACK_DEPTH  = STACK_DEPTH_C,
  parameter logic [12:0] RESET_VECTOR = RESET_VECTOR_C,
  parameter logic [13:0] NOP_WORD     = NOP_WORD_C
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                incr_pc_en,
  input  logic                load_pc_en,
  input  logic [10:0]         load_pc_addr,
  input  logic                pcl_wr_en,
  input  logic [7:0]          pcl_wr_data,
  input  logic [4:0]          pclath,
  input  logic                push_en,
  input  logic                pop_en,
  input  logic                instr_rd_en,
  input  logic                instr_flush,
  output logic [PC_WIDTH-1:0] pmem_addr,
  input  logic [13:0]         pmem_rd_data,
  output logic [13:0]         instr_current,
  output logic [PC_WIDTH-1:0] pc,
  output logic [7:0]          pcl,
  output logic                stack_overflow,
  output logic                stack_underflow
);

  localparam int SP_W = $clog2(STACK_DEPTH);

  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] stack_top;
  logic [SP_W:0]       stack_depth;

  // The stack always records the pre-update pc; on a call that is already
  // the return address because pc was advanced at fetch.
  pc_fetch_unit_return_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .WIDTH       (PC_WIDTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push_en),
    .pop       (pop_en),
    .din       (pc),
    .top       (stack_top),
    .depth     (stack_depth),
    .overflow  (stack_overflow),
    .underflow (stack_underflow)
  );

  assign pmem_addr = pc;
  assign pcl       = pc[7:0];

  // NOTE: pc_next gets a default before the priority chain so that every
  // path assigns it and no latch is inferred.
  always_comb begin
    pc_next = pc;
    if (pop_en)          pc_next = stack_top;
    else if (load_pc_en) pc_next = {pclath[4:3], load_pc_addr};
    else if (pcl_wr_en)  pc_next = {pclath, pcl_wr_data};
    else if (incr_pc_en) pc_next = pc + PC_WIDTH'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_VECTOR;
      instr_current <= NOP_WORD;
    end else begin
      pc <= pc_next;
      if (instr_flush)      instr_current <= NOP_WORD;
      else if (instr_rd_en) instr_current <= pmem_rd_data;
    end
  end

endmodule
